// File: rtl/addsub_seq_pkg.sv
// rtl/addsub_seq_pkg.sv - shared state encoding and operation constants for addsub_seq
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Subtraction is done as x + ~y + ~borrow, so the second operand and the
    // incoming carry are both inverted for OP_SUB.
    function automatic logic cond_inv(input logic opv, input logic bitv);
        return (opv == OP_SUB) ? ~bitv : bitv;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// rtl/addsub_digit.sv - DIGIT-wide combinational ripple-carry adder slice
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    // Chain of full adders, bit 0 first; the carry walks up through a local variable.
    always_comb begin
        logic carry;
        s     = '0;
        carry = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - digit-serial signed add/sub with carry/borrow-in, overflow and zero flags
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic             ci,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             of,
    output logic             co,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t           state;
    logic [WIDTH-1:0] xs;         // remaining x digits, consumed from the bottom
    logic [WIDTH-1:0] bs;         // remaining (possibly inverted) y digits
    logic             carry;      // carry between digits
    logic             op_q;
    logic             x_msb;
    logic             b_msb;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic [WIDTH-1:0] acc_full;   // all digits so far, newest digit on top
    logic             last_digit;

    // Operand conditioning at acceptance: b = ~y and c = ~ci when subtracting.
    always_comb begin
        b_in = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b_in[i] = cond_inv(op, y[i]);
        end
        c_in = cond_inv(op, ci);
    end

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (xs[DIGIT-1:0]),
        .b    (bs[DIGIT-1:0]),
        .cin  (carry),
        .s    (dsum),
        .cout (dcout)
    );

    assign last_digit = (cnt == CW'(NDIG - 1));

    // Digits already produced are kept right-shifted so that, on the last
    // digit, {dsum, acc_lo} is exactly the finished result.
    generate
        if (NDIG > 1) begin : g_acc
            logic [WIDTH-DIGIT-1:0] acc_lo;

            assign acc_full = {dsum, acc_lo};

            // Shift each freshly computed digit in from the top while running.
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_lo <= '0;
                end else if (state == RUN) begin
                    acc_lo <= acc_full[WIDTH-1:DIGIT];
                end
            end
        end else begin : g_acc_single
            assign acc_full = dsum;
        end
    endgenerate

    // Control FSM plus operand shifters and registered result/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            r         <= '0;
            of        <= 1'b0;
            co        <= 1'b0;
            zero      <= 1'b0;
            xs        <= '0;
            bs        <= '0;
            carry     <= 1'b0;
            op_q      <= OP_ADD;
            x_msb     <= 1'b0;
            b_msb     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xs       <= x;
                        bs       <= b_in;
                        carry    <= c_in;
                        op_q     <= op;
                        x_msb    <= x[WIDTH-1];
                        b_msb    <= b_in[WIDTH-1];
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    xs    <= xs >> DIGIT;
                    bs    <= bs >> DIGIT;
                    carry <= dcout;
                    cnt   <= cnt + 1'b1;
                    if (last_digit) begin
                        r         <= acc_full;
                        of        <= (x_msb == b_msb) && (acc_full[WIDTH-1] != x_msb);
                        co        <= (op_q == OP_SUB) ? ~dcout : dcout;
                        zero      <= (acc_full == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - scoreboard bench for addsub_seq with directed vectors
module tb_addsub_seq;
    import addsub_seq_pkg::*;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    typedef struct {
        string       name;
        logic [15:0] r;
        logic        of;
        logic        co;
        logic        zero;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic        ci;
    logic [15:0] x;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r;
    logic        of;
    logic        co;
    logic        zero;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    addsub_seq #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .ci        (ci),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .of        (of),
        .co        (co),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Call away from the rising edge (after a negedge); returns 1 time unit after the accepting edge.
    task automatic issue(input string name, input logic o, input logic c,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic eof, input logic eco,
                         input logic ez, input bit track);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        op       = o;
        ci       = c;
        x        = a;
        y        = b;
        for (int n = 0; n < 50 && !got; n++) begin
            if (in_ready) begin
                @(posedge clk);
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        if (!got) fail_now({name, ".accept"});
        else if (track) sb.push_back('{name, er, eof, eco, ez, cyc});
        in_valid = 1'b0;
        op       = 1'($urandom);
        ci       = 1'($urandom);
        x        = 16'($urandom);
        y        = 16'($urandom);
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) fail_now({name, ".drain"});
        @(negedge clk);
    endtask

    // Monitor: latency on each out_valid rise, result/flag compare on each handshake.
    bit   ov_prev = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) fail_now("unexpected_out_valid");
                else chk({sb[0].name, ".latency"}, cyc - sb[0].acc_cyc, NDIG);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    e = sb.pop_front();
                    chk({e.name, ".r"}, r, e.r);
                    chk({e.name, ".of"}, of, e.of);
                    chk({e.name, ".co"}, co, e.co);
                    chk({e.name, ".zero"}, zero, e.zero);
                end
            end
        end
        ov_prev = out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = OP_ADD;
        ci        = 1'b0;
        x         = '0;
        y         = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.r", r, 0);
        chk("rst.of", of, 0);
        chk("rst.co", co, 0);
        chk("rst.zero", zero, 0);
        rst = 1'b0;
        @(negedge clk);

        issue("add_ovf",   OP_ADD, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1, 0, 0, 1); wait_drain("add_ovf");
        issue("add_wrap",  OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 0, 1, 1, 1); wait_drain("add_wrap");
        issue("sub_neg",   OP_SUB, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 0, 1, 0, 1); wait_drain("sub_neg");
        issue("sub_ovf",   OP_SUB, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1, 0, 0, 1); wait_drain("sub_ovf");
        issue("sub_bin",   OP_SUB, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 0, 1, 0, 1); wait_drain("sub_bin");
        issue("add_cin",   OP_ADD, 1'b1, 16'h00FF, 16'h0001, 16'h0101, 0, 0, 0, 1); wait_drain("add_cin");
        issue("sub_bin2",  OP_SUB, 1'b1, 16'h1000, 16'h0001, 16'h0FFE, 0, 0, 0, 1); wait_drain("sub_bin2");

        // Back-pressure: result held while a new request is pending
        out_ready = 1'b0;
        issue("bp_a", OP_ADD, 1'b0, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0, 1);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        if (!out_valid) fail_now("bp.out_valid");
        in_valid = 1'b1;
        op       = OP_ADD;
        ci       = 1'b0;
        x        = 16'h0100;
        y        = 16'h0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp.out_valid", out_valid, 1);
            chk("bp.in_ready", in_ready, 0);
            chk("bp.r", r, 16'h2345);
            chk("bp.flags", {of, co, zero}, 3'b000);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp.idle_in_ready", in_ready, 1);
        chk("bp.idle_out_valid", out_valid, 0);
        c0 = cyc;
        issue("bp_b", OP_ADD, 1'b0, 16'h0100, 16'h0001, 16'h0101, 0, 0, 0, 1);
        chk("bp.accept_edge", cyc, c0 + 1);
        wait_drain("bp_b");

        // Reset during the second RUN cycle discards the operation
        issue("rst_mid", OP_ADD, 1'b0, 16'h0003, 16'h0004, 16'h0007, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid.in_ready", in_ready, 1);
        chk("rst_mid.out_valid", out_valid, 0);
        chk("rst_mid.r", r, 0);
        rst = 1'b0;
        @(negedge clk);
        issue("after_rst", OP_ADD, 1'b0, 16'h0003, 16'h0004, 16'h0007, 0, 0, 0, 1);
        wait_drain("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
